mem_lsu_ysyx_23060136: RTL and testbench

//  MEM-stage load/store unit. Turns the load/store held in the EX/MEM segment register into AXI4-Lite master transactions.

---
 rtl/DEFINES_ysyx_23060136.sv | 22 ++
 rtl/lsu_align_ysyx_23060136.sv | 55 +++++
 rtl/mem_lsu_ysyx_23060136.sv | 161 ++++++++++++++++
 tb/tb_mem_lsu_ysyx_23060136.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/DEFINES_ysyx_23060136.sv
// Shared LSU definitions: funct3 encodings,
// FSM state type and AXI response constants.
package DEFINES_ysyx_23060136;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WREQ,
    S_B,
    S_HOLD
  } lsu_state_t;

endpackage

// File: rtl/lsu_align_ysyx_23060136.sv
// Lane steering: store strobe/data, load extract/extend, misalign.
// Ports: func3, lane (addr[1:0]), st_data, bus_rdata -> wstrb, wdata, ld_data, misalign.
module lsu_align_ysyx_23060136 (
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] st_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misalign
);
  import DEFINES_ysyx_23060136::*;

  logic        is_h;
  logic        is_w;
  logic [31:0] shifted;

  assign is_h = (func3[1:0] == 2'b01);
  assign is_w = (func3[1:0] == 2'b10);

  assign misalign = (is_h & lane[0])
                  | (is_w & (lane != 2'b00));

  // Addressed byte lands in bits [7:0]
  assign shifted = bus_rdata >> {lane, 3'b000};

  always_comb begin
    wstrb = 4'b0001 << lane;
    wdata = {4{st_data[7:0]}};
    unique case (1'b1)
      is_w: begin
        wstrb = 4'hF;
        wdata = st_data;
      end
      is_h: begin
        wstrb = 4'b0011 << lane;
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = shifted;
    case (func3)
      F3_B:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU: ld_data = {24'd0, shifted[7:0]};
      F3_HU: ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu_ysyx_23060136.sv
// MEM-stage LSU: EX/MEM load/store -> AXI4-Lite master, plus stall handshake.
// Ports: MEM_i_* segment inputs, pipe_advance; MEM_* status/data out; io_* AXI4-Lite master.
module mem_lsu_ysyx_23060136 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_i_valid,
  input  logic              MEM_i_mem_to_reg,
  input  logic              MEM_i_write_mem,
  input  logic [2:0]        MEM_i_func3,
  input  logic [ADDR_W-1:0] MEM_i_ALU_ALUout,
  input  logic [DATA_W-1:0] MEM_i_rs2_data,
  input  logic              pipe_advance,
  output logic              MEM_rvalid,
  output logic              MEM_wready,
  output logic [DATA_W-1:0] MEM_o_rdata,
  output logic              MEM_o_misalign,
  output logic              MEM_o_bus_err,
  output logic [ADDR_W-1:0] io_araddr,
  output logic              io_arvalid,
  input  logic              io_arready,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic [1:0]        io_rresp,
  input  logic              io_rvalid,
  output logic              io_rready,
  output logic [ADDR_W-1:0] io_awaddr,
  output logic              io_awvalid,
  input  logic              io_awready,
  output logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W/8-1:0] io_wstrb,
  output logic              io_wvalid,
  input  logic              io_wready,
  input  logic [1:0]        io_bresp,
  input  logic              io_bvalid,
  output logic              io_bready
);
  import DEFINES_ysyx_23060136::*;

  lsu_state_t        state, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              is_ld, is_st;
  logic              mis;
  logic [31:0]       ld_data;

  assign is_ld = MEM_i_valid & MEM_i_mem_to_reg;
  assign is_st = MEM_i_valid & MEM_i_write_mem;

  lsu_align_ysyx_23060136 u_align (
    .func3     (MEM_i_func3),
    .lane      (MEM_i_ALU_ALUout[1:0]),
    .st_data   (MEM_i_rs2_data),
    .bus_rdata (io_rdata),
    .wstrb     (io_wstrb),
    .wdata     (io_wdata),
    .ld_data   (ld_data),
    .misalign  (mis)
  );

  // Segment register is frozen while stalled, so the
  // address can drive the bus directly.
  assign io_araddr = {MEM_i_ALU_ALUout[ADDR_W-1:2], 2'b00};
  assign io_awaddr = {MEM_i_ALU_ALUout[ADDR_W-1:2], 2'b00};

  assign MEM_rvalid = (state == S_HOLD)
                    | ((state == S_IDLE) & ~is_ld);
  assign MEM_wready = (state == S_HOLD)
                    | ((state == S_IDLE) & ~is_st);

  assign MEM_o_rdata    = rdata_q;
  assign MEM_o_bus_err  = err_q;
  assign MEM_o_misalign = mis_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state     <= state_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d    = state;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mis_d      = mis_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    io_arvalid = 1'b0;
    io_rready  = 1'b0;
    io_awvalid = 1'b0;
    io_wvalid  = 1'b0;
    io_bready  = 1'b0;
    unique case (state)
      S_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if ((is_ld | is_st) & mis) begin
          state_d = S_HOLD;
          mis_d   = 1'b1;
          rdata_d = '0;
        end else if (is_ld) begin
          state_d = S_AR;
        end else if (is_st) begin
          state_d = S_WREQ;
        end
      end
      S_AR: begin
        io_arvalid = 1'b1;
        if (io_arready) state_d = S_R;
      end
      S_R: begin
        io_rready = 1'b1;
        if (io_rvalid) begin
          rdata_d = ld_data;
          err_d   = (io_rresp != RESP_OKAY);
          state_d = S_HOLD;
        end
      end
      S_WREQ: begin
        // AW and W retire independently
        io_awvalid = ~aw_done_q;
        io_wvalid  = ~w_done_q;
        aw_done_d  = aw_done_q | io_awready;
        w_done_d   = w_done_q | io_wready;
        if (aw_done_d & w_done_d) state_d = S_B;
      end
      S_B: begin
        io_bready = 1'b1;
        if (io_bvalid) begin
          err_d   = (io_bresp != RESP_OKAY);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pipe_advance) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
          mis_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu_ysyx_23060136.sv
// Bench for mem_lsu_ysyx_23060136: random loads/stores
// against a lane-arithmetic reference and a delay-programmable slave.
module tb_mem_lsu_ysyx_23060136;

  logic        clk;
  logic        rst_n;
  logic        MEM_i_valid;
  logic        MEM_i_mem_to_reg;
  logic        MEM_i_write_mem;
  logic [2:0]  MEM_i_func3;
  logic [31:0] MEM_i_ALU_ALUout;
  logic [31:0] MEM_i_rs2_data;
  logic        pipe_advance;
  logic        MEM_rvalid;
  logic        MEM_wready;
  logic [31:0] MEM_o_rdata;
  logic        MEM_o_misalign;
  logic        MEM_o_bus_err;
  logic [31:0] io_araddr;
  logic        io_arvalid;
  logic        io_arready;
  logic [31:0] io_rdata;
  logic [1:0]  io_rresp;
  logic        io_rvalid;
  logic        io_rready;
  logic [31:0] io_awaddr;
  logic        io_awvalid;
  logic        io_awready;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        io_wvalid;
  logic        io_wready;
  logic [1:0]  io_bresp;
  logic        io_bvalid;
  logic        io_bready;

  mem_lsu_ysyx_23060136 dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .MEM_i_valid      (MEM_i_valid),
    .MEM_i_mem_to_reg (MEM_i_mem_to_reg),
    .MEM_i_write_mem  (MEM_i_write_mem),
    .MEM_i_func3      (MEM_i_func3),
    .MEM_i_ALU_ALUout (MEM_i_ALU_ALUout),
    .MEM_i_rs2_data   (MEM_i_rs2_data),
    .pipe_advance     (pipe_advance),
    .MEM_rvalid       (MEM_rvalid),
    .MEM_wready       (MEM_wready),
    .MEM_o_rdata      (MEM_o_rdata),
    .MEM_o_misalign   (MEM_o_misalign),
    .MEM_o_bus_err    (MEM_o_bus_err),
    .io_araddr        (io_araddr),
    .io_arvalid       (io_arvalid),
    .io_arready       (io_arready),
    .io_rdata         (io_rdata),
    .io_rresp         (io_rresp),
    .io_rvalid        (io_rvalid),
    .io_rready        (io_rready),
    .io_awaddr        (io_awaddr),
    .io_awvalid       (io_awvalid),
    .io_awready       (io_awready),
    .io_wdata         (io_wdata),
    .io_wstrb         (io_wstrb),
    .io_wvalid        (io_wvalid),
    .io_wready        (io_wready),
    .io_bresp         (io_bresp),
    .io_bvalid        (io_bvalid),
    .io_bready        (io_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Slave configuration and observation
  int          c_ar, c_r, c_aw, c_w, c_b;
  logic [1:0]  c_resp;
  logic [31:0] slv_word;
  int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
  logic [31:0] last_araddr, last_wdata;
  logic [3:0]  last_wstrb;
  bit          rd_pend, b_pend, aw_got, w_got;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;

  // Slave acts on the falling edge; handshakes complete
  // at the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      io_arready = 0; io_rvalid = 0;
      io_rdata = 0;   io_rresp = 0;
      io_awready = 0; io_wready = 0;
      io_bvalid = 0;  io_bresp = 0;
      rd_pend = 0; b_pend = 0;
      aw_got = 0;  w_got = 0;
      ar_cnt = 0; r_cnt = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      io_rvalid = 0;
      if (rd_pend) begin
        if (r_cnt >= c_r) begin
          io_rvalid = 1;
          io_rdata  = slv_word;
          io_rresp  = c_resp;
          if (io_rready) rd_pend = 0;
        end else r_cnt++;
      end
      io_arready = 0;
      if (io_arvalid && !rd_pend) begin
        if (ar_cnt >= c_ar) begin
          io_arready  = 1;
          ar_cnt      = 0;
          rd_pend     = 1;
          r_cnt       = 0;
          last_araddr = io_araddr;
          n_ar++;
        end else ar_cnt++;
      end
      io_bvalid = 0;
      if (b_pend) begin
        if (b_cnt >= c_b) begin
          io_bvalid = 1;
          io_bresp  = c_resp;
          if (io_bready) begin
            b_pend = 0;
            n_b++;
          end
        end else b_cnt++;
      end
      io_awready = 0;
      if (io_awvalid && !aw_got) begin
        if (aw_cnt >= c_aw) begin
          io_awready = 1;
          aw_got = 1;
          aw_cnt = 0;
          n_aw++;
        end else aw_cnt++;
      end
      io_wready = 0;
      if (io_wvalid && !w_got) begin
        if (w_cnt >= c_w) begin
          io_wready  = 1;
          w_got      = 1;
          w_cnt      = 0;
          last_wdata = io_wdata;
          last_wstrb = io_wstrb;
          n_w++;
        end else w_cnt++;
      end
      if (aw_got && w_got) begin
        aw_got = 0;
        w_got  = 0;
        b_pend = 1;
        b_cnt  = 0;
      end
    end
  end

  // Reference model: access size in bytes from funct3
  function automatic int unsigned sz(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] f3,
                               input logic [31:0] a);
    return (a % sz(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(
      input logic [2:0] f3, input logic [31:0] a,
      input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) % 256;
    h = (w >> (8 * (a % 4))) % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_strb(
      input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] m;
    m = (32'd1 << sz(f3)) - 1;
    return m << (a % 4);
  endfunction

  function automatic logic [31:0] m_wdata(
      input logic [2:0] f3, input logic [31:0] d);
    if (sz(f3) == 1) return (d % 256) * 32'h0101_0101;
    if (sz(f3) == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  task automatic do_op(input bit ld, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] rs2,
                       input logic [31:0] w, input logic [1:0] resp,
                       input int al, input int rl, input int awl,
                       input int wl, input int bl, input int hold);
    int  ar0, aw0, w0, b0, cyc, lat;
    bit  mis;
    logic [31:0] er;
    c_ar = al; c_r = rl; c_aw = awl; c_w = wl; c_b = bl;
    c_resp   = resp;
    slv_word = w;
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; b0 = n_b;
    mis = m_mis(f3, a);
    er  = m_load(f3, a, w);
    if (mis) lat = 1;
    else if (ld) lat = 3 + al + rl;
    else lat = 3 + ((awl > wl) ? awl : wl) + bl;
    MEM_i_valid      = 1;
    MEM_i_mem_to_reg = ld;
    MEM_i_write_mem  = !ld;
    MEM_i_func3      = f3;
    MEM_i_ALU_ALUout = a;
    MEM_i_rs2_data   = rs2;
    #1;
    chk("idle_rvalid", 32'(MEM_rvalid), 32'(!ld));
    chk("idle_wready", 32'(MEM_wready), 32'(ld));
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!(MEM_rvalid && MEM_wready) && cyc < 40);
    chk("latency", 32'(cyc), 32'(lat));
    chk("misalign", 32'(MEM_o_misalign), 32'(mis));
    chk("bus_err", 32'(MEM_o_bus_err),
        32'(!mis && resp != 0));
    if (ld && !mis) begin
      chk("rdata", MEM_o_rdata, er);
      chk("araddr", last_araddr, a & ~32'd3);
    end
    if (ld && mis) chk("mis_rdata", MEM_o_rdata, 0);
    if (!ld && !mis) begin
      chk("wstrb", 32'(last_wstrb), m_strb(f3, a));
      chk("wdata", last_wdata, m_wdata(f3, rs2));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_rvalid", 32'(MEM_rvalid), 1);
      chk("hold_err", 32'(MEM_o_bus_err),
          32'(!mis && resp != 0));
      if (ld) chk("hold_rdata", MEM_o_rdata, mis ? 0 : er);
    end
    pipe_advance = 1;
    @(posedge clk); #1;
    pipe_advance = 0;
    MEM_i_valid  = 0;
    #1;
    chk("adv_err", 32'(MEM_o_bus_err), 0);
    chk("adv_mis", 32'(MEM_o_misalign), 0);
    chk("adv_rvalid", 32'(MEM_rvalid), 1);
    @(posedge clk); #1;
    chk("n_ar", 32'(n_ar - ar0), 32'(ld && !mis));
    chk("n_aw", 32'(n_aw - aw0), 32'(!ld && !mis));
    chk("n_w", 32'(n_w - w0), 32'(!ld && !mis));
    chk("n_b", 32'(n_b - b0), 32'(!ld && !mis));
  endtask

  logic [2:0] lf3 [5];
  logic [2:0] sf3 [3];

  initial begin
    lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    sf3 = '{3'd0, 3'd1, 3'd2};
    c_ar = 0; c_r = 0; c_aw = 0; c_w = 0; c_b = 0;
    c_resp = 0; slv_word = 0;
    rst_n = 0;
    pipe_advance = 0;
    MEM_i_valid = 0;
    MEM_i_mem_to_reg = 0;
    MEM_i_write_mem = 0;
    MEM_i_func3 = 0;
    MEM_i_ALU_ALUout = 0;
    MEM_i_rs2_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", 32'(io_arvalid), 0);
    chk("rst_awvalid", 32'(io_awvalid), 0);
    chk("rst_wvalid", 32'(io_wvalid), 0);
    chk("rst_rready", 32'(io_rready), 0);
    chk("rst_bready", 32'(io_bready), 0);
    chk("rst_rdata", MEM_o_rdata, 0);
    chk("rst_err", 32'(MEM_o_bus_err), 0);
    chk("rst_mis", 32'(MEM_o_misalign), 0);
    chk("rst_rvalid", 32'(MEM_rvalid), 1);
    rst_n = 1;
    @(posedge clk); #1;

    // LW, zero-wait slave
    do_op(1, 3'd2, 32'h8000_0004, 0, 32'hDEAD_BEEF,
          0, 0, 0, 0, 0, 0, 1);
    chk("lw_const", MEM_o_rdata, 32'hDEAD_BEEF);
    // LB / LBU on top byte 0x80
    do_op(1, 3'd0, 32'h8000_0003, 0, 32'h8012_3456,
          0, 0, 0, 0, 0, 0, 0);
    chk("lb_const", MEM_o_rdata, 32'hFFFF_FF80);
    do_op(1, 3'd4, 32'h8000_0003, 0, 32'h8012_3456,
          0, 0, 0, 0, 0, 0, 0);
    chk("lbu_const", MEM_o_rdata, 32'h0000_0080);
    // SH upper half, AW accepted 2 cycles after W
    do_op(0, 3'd1, 32'h8000_0002, 32'h1234_ABCD, 0,
          0, 0, 0, 2, 0, 0, 1);
    chk("sh_strb", 32'(last_wstrb), 32'h0000_000C);
    chk("sh_data", last_wdata, 32'hABCD_ABCD);
    // Misaligned LW
    do_op(1, 3'd2, 32'h8000_0002, 0, 32'h1111_1111,
          0, 0, 0, 0, 0, 0, 1);
    // SLVERR on read, long hold
    do_op(1, 3'd2, 32'h8000_0010, 0, 32'h0BAD_F00D,
          2'b10, 1, 2, 0, 0, 0, 4);

    // Reset while waiting in R
    c_ar = 0; c_r = 5; c_resp = 0;
    MEM_i_valid = 1;
    MEM_i_mem_to_reg = 1;
    MEM_i_write_mem = 0;
    MEM_i_func3 = 3'd2;
    MEM_i_ALU_ALUout = 32'h8000_0020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_rready", 32'(io_rready), 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("midrst_arvalid", 32'(io_arvalid), 0);
    chk("midrst_rready", 32'(io_rready), 0);
    MEM_i_mem_to_reg = 0;
    #1;
    chk("midrst_rvalid", 32'(MEM_rvalid), 1);
    rst_n = 1;
    @(posedge clk); #1;
    MEM_i_valid = 0;
    @(posedge clk); #1;
    chk("post_rst_rready", 32'(io_rready), 0);

    for (int i = 0; i < 60; i++) begin
      bit          ld;
      logic [2:0]  f3;
      logic [1:0]  rs;
      ld = 1'($urandom_range(0, 1));
      if (ld) f3 = lf3[$urandom_range(0, 4)];
      else    f3 = sf3[$urandom_range(0, 2)];
      rs = ($urandom_range(0, 3) == 0)
         ? 2'($urandom_range(1, 3)) : 2'b00;
      do_op(ld, f3, $urandom, $urandom, $urandom, rs,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
